// File: rtl/difftest_frame_collector_if.sv
// rtl/difftest_frame_collector_if.sv - word-in / frame-out handshake bundle for difftest_frame_collector
//
// Purpose: groups the input word stream and the presented-frame handshake.
// Signals:
//   in_valid, in_data[IN_WIDTH], in_last : upstream word stream into the collector
//   in_ready                             : collector accepts the word on in_valid && in_ready
//   data_valid, data[DATA_WIDTH]         : complete frame presented downstream
//   data_next                            : downstream sampling indicator, falls 1->0 after capture
// Modports: master = upstream/downstream side, slave = collector.
interface difftest_frame_collector_if #(
  parameter int DATA_WIDTH = 4064,
  parameter int IN_WIDTH   = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_last;
  logic                  data_valid;
  logic                  data_next;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output in_valid, in_data, in_last, data_next,
    input  in_ready, data_valid, data
  );

  modport slave (
    input  in_valid, in_data, in_last, data_next,
    output in_ready, data_valid, data
  );
endinterface

// File: rtl/difftest_frame_collector.sv
// rtl/difftest_frame_collector.sv - ping-pong collector packing IN_WIDTH words into DATA_WIDTH frames
//
// Purpose: accepts a stream of IN_WIDTH words, packs them word 0 at LSB into one of
// two DATA_WIDTH buffers, closes a buffer on its last word slot or on in_last, and
// presents closed buffers downstream in closing order. A presented frame is retired
// when data_next shows a 1 -> 0 fall while the frame is presented.
// Ports:
//   m_axis_c2h_aclk    : clock, rising edge
//   m_axis_c2h_aresetn : synchronous active-low reset
//   rst_en             : synchronous active-low soft reset, same effect as aresetn
//   bus (slave)        : in_valid/in_ready/in_data/in_last, data_valid/data_next/data
//   fill_cnt[8]        : words written into the current fill buffer
//   buf_full[2]        : per-buffer full flags
//   drop_cnt[16]       : saturating count of discarded words (COLLECTOR_DROP_ON_FULL_EN only)
// Configuration macro: COLLECTOR_DROP_ON_FULL_EN
//   undefined : backpressure, in_ready = !buf_full[wr_sel], no word is ever lost
//   defined   : in_ready held 1 outside reset, words arriving into a full buffer are dropped
module difftest_frame_collector #(
  parameter int DATA_WIDTH = 4064,
  parameter int IN_WIDTH   = 32
) (
  input  logic                     m_axis_c2h_aclk,
  input  logic                     m_axis_c2h_aresetn,
  input  logic                     rst_en,
  difftest_frame_collector_if.slave bus,
  output logic [7:0]               fill_cnt,
  output logic [1:0]               buf_full
`ifdef COLLECTOR_DROP_ON_FULL_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int         WORDS    = DATA_WIDTH / IN_WIDTH;
  localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RETIRE  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] frame_buf [2];
  logic [DATA_WIDTH-1:0] data_q;
  logic                  data_valid_q;
  logic                  in_ready_q;
  logic                  next_q;
  logic                  wr_sel;
  logic                  rd_sel;
  logic                  rstn;

  logic                  hs;
  logic                  wr_en;
  logic                  close;
  logic                  retire;
  logic [1:0]            buf_full_nxt;
  logic                  wr_sel_nxt;
  logic                  in_ready_nxt;

  assign rstn = m_axis_c2h_aresetn & rst_en;

  assign bus.in_ready   = in_ready_q;
  assign bus.data_valid = data_valid_q;
  assign bus.data       = data_q;

  // Close and retire always hit different buffers: a buffer being filled is never
  // full and the retired one always is, so both updates can land in one cycle.
  always_comb begin
    hs           = bus.in_valid & in_ready_q;
    wr_en        = hs & ~buf_full[wr_sel];
    close        = wr_en & (bus.in_last | (fill_cnt == LAST_IDX));
    retire       = (state == RETIRE);
    buf_full_nxt = buf_full;
    if (close) begin
      buf_full_nxt[wr_sel] = 1'b1;
    end
    if (retire) begin
      buf_full_nxt[rd_sel] = 1'b0;
    end
    wr_sel_nxt = wr_sel ^ close;
`ifdef COLLECTOR_DROP_ON_FULL_EN
    in_ready_nxt = 1'b1;
`else
    // in_ready is registered from next-state flags so it always equals
    // !buf_full[wr_sel] as seen on the outputs.
    in_ready_nxt = ~buf_full_nxt[wr_sel_nxt];
`endif
  end

  // Word 0 overwrites the whole buffer so slots never written read as zero,
  // which also hides anything left over from before a reset.
  always_ff @(posedge m_axis_c2h_aclk) begin
    if (wr_en) begin
      if (fill_cnt == 8'd0) begin
        frame_buf[wr_sel] <= DATA_WIDTH'(bus.in_data);
      end else begin
        frame_buf[wr_sel][fill_cnt*IN_WIDTH +: IN_WIDTH] <= bus.in_data;
      end
    end
  end

  always_ff @(posedge m_axis_c2h_aclk) begin
    if (!rstn) begin
      state        <= IDLE;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      buf_full     <= 2'b00;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      fill_cnt     <= 8'd0;
      in_ready_q   <= 1'b0;
      next_q       <= 1'b0;
`ifdef COLLECTOR_DROP_ON_FULL_EN
      drop_cnt     <= 16'd0;
`endif
    end else begin
      buf_full   <= buf_full_nxt;
      wr_sel     <= wr_sel_nxt;
      in_ready_q <= in_ready_nxt;
      next_q     <= bus.data_next;

      if (close) begin
        fill_cnt <= 8'd0;
      end else if (wr_en) begin
        fill_cnt <= fill_cnt + 8'd1;
      end

`ifdef COLLECTOR_DROP_ON_FULL_EN
      if (hs && buf_full[wr_sel] && (drop_cnt != 16'hffff)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
`endif

      case (state)
        IDLE: begin
          if (buf_full[rd_sel]) begin
            state        <= PRESENT;
            data_q       <= frame_buf[rd_sel];
            data_valid_q <= 1'b1;
          end
        end
        PRESENT: begin
          // Only a 1 -> 0 fall of data_next retires; a level high holds the frame.
          if (next_q && !bus.data_next) begin
            state        <= RETIRE;
            data_valid_q <= 1'b0;
          end
        end
        RETIRE: begin
          rd_sel <= ~rd_sel;
          state  <= IDLE;
        end
        default: begin
          state        <= IDLE;
          data_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/difftest_frame_collector.md
DIFFTEST_FRAME_COLLECTOR -- requirements
Module: difftest_frame_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 4064, frame width delivered downstream; SHALL be an integer multiple of IN_WIDTH.
REQ-002 Parameter IN_WIDTH, default 32, input word width; WORDS = DATA_WIDTH/IN_WIDTH (127 at defaults).
REQ-003 m_axis_c2h_aclk  in  1  sole clock; all logic on its rising edge.
REQ-004 m_axis_c2h_aresetn  in  1  synchronous, active-low reset.
REQ-005 rst_en  in  1  synchronous soft reset, active-low, same effect as m_axis_c2h_aresetn.
REQ-006 in_valid  in  1  input word valid.
REQ-007 in_ready  out  1  input word accepted when in_valid && in_ready.
REQ-008 in_data  in  IN_WIDTH  input word.
REQ-009 in_last  in  1  qualified by in_valid; closes the current frame after this word.
REQ-010 data_valid  out  1  a complete frame is presented on data.
REQ-011 data_next  in  1  downstream idle/sampling indicator; falls 1->0 the cycle after it captures data.
REQ-012 data  out  DATA_WIDTH  presented frame.
REQ-013 fill_cnt  out  8  words written into the current fill buffer.
REQ-014 buf_full  out  2  per-buffer full flags, bit i = buffer i.

Function
REQ-015 Two DATA_WIDTH ping-pong buffers; fill pointer wr_sel and present pointer rd_sel, each 1 bit, toggle on buffer completion/retirement.
REQ-016 Accepted word k SHALL be written to bits [k*IN_WIDTH +: IN_WIDTH] of buffer wr_sel, word 0 at LSB.
REQ-017 A buffer SHALL close when word WORDS-1 is accepted or when in_last is accepted; unwritten words SHALL read as zero (buffer cleared when opened).
REQ-018 On close: buf_full[wr_sel] set, wr_sel toggles, fill_cnt returns to 0, all in the same cycle.
REQ-019 in_ready SHALL be 1 when buf_full[wr_sel] is 0, else 0.
REQ-020 Output FSM states: IDLE, PRESENT, RETIRE.
REQ-021 IDLE -> PRESENT when buf_full[rd_sel]=1; data_valid asserts the cycle after entering PRESENT condition is registered (1-cycle latency from close).
REQ-022 PRESENT: data and data_valid held stable; data_next registered each cycle; on registered 1 followed by current 0 (falling edge) -> RETIRE.
REQ-023 data_next high without a falling edge SHALL NOT retire a frame.
REQ-024 RETIRE (1 cycle): data_valid=0, buf_full[rd_sel] cleared, rd_sel toggles, -> IDLE.
REQ-025 Simultaneous close of one buffer and retire of the other SHALL both take effect in that cycle.
REQ-026 in_last on a word when fill_cnt=WORDS-1 SHALL close exactly one frame.
REQ-027 Frames SHALL be delivered in closing order; none duplicated or lost (except under REQ-032).

Reset
REQ-028 While m_axis_c2h_aresetn=0 or rst_en=0 at a clock edge: FSM IDLE, data_valid=0, data=0, buf_full=0, wr_sel=rd_sel=0, fill_cnt=0, in_ready=1 next cycle after release (0 during reset).
REQ-029 Reset mid-frame or mid-PRESENT SHALL discard all buffered data; no partial frame is emitted afterwards.

Configuration
REQ-030 Macro COLLECTOR_DROP_ON_FULL_EN selects full-buffer policy.
REQ-031 Undefined: backpressure per REQ-019; no word ever dropped.
REQ-032 Defined: in_ready constant 1 (0 only in reset); words arriving while buf_full[wr_sel]=1 discarded; extra output drop_cnt (16 bits, saturating, reset 0) counts discarded words.

Verification
REQ-033 127 consecutive words value k -> one frame, data word k = k, data_valid 1 cycle after last accept, fill_cnt back to 0.
REQ-034 5 words then in_last on 6th -> frame words 0..5 = data, words 6..126 = 0.
REQ-035 Hold data_next=1 for 20 cycles with data_valid=1 -> frame stays presented; drop data_next to 0 -> data_valid=0 two cycles later, next frame presented if pending.
REQ-036 Three full frames streamed with data_next stuck at 1 (no fall) -> both buffers full, in_ready=0 after word 254, third frame stalled with no loss; releasing handshake delivers frames 1,2,3 in order.
REQ-037 Assert rst_en=0 at word 60 of a frame while another frame presented -> data_valid=0, buf_full=0, fill_cnt=0; post-reset frame contains only post-reset words.
REQ-038 With COLLECTOR_DROP_ON_FULL_EN, repeat REQ-036 stimulus -> in_ready stays 1, drop_cnt=127, frames 1,2 delivered intact.
